// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module : rv32i_pkg
//  Brief  : RV32I ALU opcodes, instruction field constants, decoded bundle
//  Rev    : 1.0
// ============================================================================
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      alu_control;
        logic [4:0]      rd;
        logic            slt_sel;
        logic            illegal;
    } dec_bundle_t;

    localparam dec_bundle_t DEC_RESET = '{
        a:           '0,
        b:           '0,
        alu_control: ALU_ADD,
        rd:          5'd0,
        slt_sel:     1'b0,
        illegal:     1'b0
    };

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module : alu_issue_stage_if
//  Brief  : Instruction in, regfile read and EX-stage out bundle
//  Rev    : 1.0
// ============================================================================
interface alu_issue_stage_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic [4:0]  rd;
    logic        slt_sel;
    logic        illegal;

    // Environment side: fetch, register file and EX stage
    modport master (
        output instr_valid, instr, rs1_data, rs2_data, ex_ready,
        input  instr_ready, rs1_addr, rs2_addr, ex_valid,
               A, B, ALUControl, rd, slt_sel, illegal
    );

    modport slave (
        input  instr_valid, instr, rs1_data, rs2_data, ex_ready,
        output instr_ready, rs1_addr, rs2_addr, ex_valid,
               A, B, ALUControl, rd, slt_sel, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module : alu_op_decode
//  Brief  : Combinational OP / OP-IMM decode into ALU operands and opcode
//  Rev    : 1.0
// ============================================================================
module alu_op_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output dec_bundle_t dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_op;
    logic        is_imm;
    logic        legal;
    logic        slt;
    logic [3:0]  alu;
    logic [31:0] b_val;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign is_op    = (opcode == OPC_OP);
    assign is_imm   = (opcode == OPC_OPIMM);

    always_comb begin
        legal = 1'b0;
        slt   = 1'b0;
        alu   = ALU_ADD;
        case (funct3)
            F3_ADD: begin
                // SUB only exists in the register form; ADDI uses funct7 as immediate
                legal = is_imm | (funct7 == F7_BASE) | (funct7 == F7_ALT);
                alu   = (is_op && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            end
            F3_SLL: begin
                legal = (funct7 == F7_BASE);
                alu   = ALU_SLL;
            end
            F3_SR: begin
                legal = (funct7 == F7_BASE) | (funct7 == F7_ALT);
                alu   = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            end
            F3_SLT: begin
                legal = is_imm | (funct7 == F7_BASE);
                alu   = ALU_SUB;
                slt   = 1'b1;
            end
            F3_XOR: begin
                legal = is_imm | (funct7 == F7_BASE);
                alu   = ALU_XOR;
            end
            F3_OR: begin
                legal = is_imm | (funct7 == F7_BASE);
                alu   = ALU_OR;
            end
            F3_AND: begin
                legal = is_imm | (funct7 == F7_BASE);
                alu   = ALU_AND;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        legal = legal & (is_op | is_imm);

        if (is_op) begin
            b_val = rs2_data;
        end else if (funct3 == F3_SLL || funct3 == F3_SR) begin
            b_val = {27'b0, instr[24:20]};
        end else begin
            b_val = imm_i(instr);
        end

        dec = DEC_RESET;
        if (legal) begin
            dec.a           = rs1_data;
            dec.b           = b_val;
            dec.alu_control = alu;
            dec.rd          = instr[11:7];
            dec.slt_sel     = slt;
        end else begin
            dec.illegal     = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module : alu_issue_stage
//  Brief  : RV32I ALU operand issue with output register and skid buffer
//  Rev    : 1.0
// ============================================================================
module alu_issue_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_issue_stage_if.slave  bus
);

    dec_bundle_t dec;
    dec_bundle_t out_q;
    dec_bundle_t out_d;
    dec_bundle_t skid_q;
    dec_bundle_t skid_d;
    logic        out_valid_q;
    logic        out_valid_d;
    logic        skid_valid_q;
    logic        skid_valid_d;
    logic        accept;
    logic        load_out;

    alu_op_decode u_decode (
        .instr    (bus.instr),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data),
        .rs1_addr (bus.rs1_addr),
        .rs2_addr (bus.rs2_addr),
        .dec      (dec)
    );

    // With the skid present, ready comes straight from a flop so ex_ready never
    // reaches upstream combinationally; without it the skid simply never fills.
    generate
        if (SKID_EN) begin : g_ready_skid
            assign bus.instr_ready = ~skid_valid_q;
        end else begin : g_ready_noskid
            assign bus.instr_ready = ~out_valid_q | bus.ex_ready;
        end
    endgenerate

    assign accept   = bus.instr_valid & bus.instr_ready;
    assign load_out = ~out_valid_q | bus.ex_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_out) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = dec;
                end
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= DEC_RESET;
            skid_valid_q <= 1'b0;
            skid_q       <= DEC_RESET;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign bus.ex_valid   = out_valid_q;
    assign bus.A          = out_q.a[XLEN-1:0];
    assign bus.B          = out_q.b[XLEN-1:0];
    assign bus.ALUControl = out_q.alu_control;
    assign bus.rd         = out_q.rd;
    assign bus.slt_sel    = out_q.slt_sel;
    assign bus.illegal    = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module : tb_alu_issue_stage
//  Brief  : Self-checking bench for alu_issue_stage against a queue model
//  Rev    : 1.0
// ============================================================================
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        slt;
        logic        ill;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] regs [32];
    exp_t        q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    assign bus.rs1_data = regs[bus.rs1_addr];
    assign bus.rs2_data = regs[bus.rs2_addr];

    alu_issue_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference decode written from the ISA rules: pick the mnemonic, then map.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t        e;
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        bit          reg_form = (opc == 7'h33);
        bit          imm_form = (opc == 7'h13);
        bit          ok;
        logic [3:0]  code;
        logic [31:0] imm = {{20{ins[31]}}, ins[31:20]};
        ok   = 0;
        code = 4'd2;
        case (f3)
            3'd0: begin ok = imm_form || f7 == 7'h00 || f7 == 7'h20;
                        code = (reg_form && f7 == 7'h20) ? 4'd6 : 4'd2; end
            3'd1: begin ok = (f7 == 7'h00); code = 4'd4; end
            3'd5: begin ok = (f7 == 7'h00 || f7 == 7'h20); code = (f7 == 7'h20) ? 4'd7 : 4'd5; end
            3'd2: begin ok = imm_form || f7 == 7'h00; code = 4'd6; end
            3'd4: begin ok = imm_form || f7 == 7'h00; code = 4'd3; end
            3'd6: begin ok = imm_form || f7 == 7'h00; code = 4'd1; end
            3'd7: begin ok = imm_form || f7 == 7'h00; code = 4'd0; end
            default: ok = 0;
        endcase
        ok = ok && (reg_form || imm_form);
        if (!ok) begin
            e = '{a: 32'd0, b: 32'd0, alu: 4'd2, rd: 5'd0, slt: 1'b0, ill: 1'b1};
        end else begin
            e.a   = regs[ins[19:15]];
            e.b   = reg_form ? regs[ins[24:20]] : ((f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : imm);
            e.alu = code;
            e.rd  = ins[11:7];
            e.slt = (f3 == 3'd2);
            e.ill = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int          k = $urandom_range(0, 7);
        int          m = $urandom_range(0, 3);
        if (k < 3)      r[6:0] = 7'h33;
        else if (k < 6) r[6:0] = 7'h13;
        if (m == 0)      r[31:25] = 7'h00;
        else if (m == 1) r[31:25] = 7'h20;
        return r;
    endfunction

    // Compare one cycle at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        bit acc;
        bit con;
        @(negedge clk);
        check("instr_ready", bus.instr_ready, q.size() < 2);
        check("ex_valid", bus.ex_valid, q.size() > 0);
        check("rs1_addr", bus.rs1_addr, bus.instr[19:15]);
        check("rs2_addr", bus.rs2_addr, bus.instr[24:20]);
        if (q.size() > 0) begin
            check("A", bus.A, q[0].a);
            check("B", bus.B, q[0].b);
            check("ALUControl", bus.ALUControl, q[0].alu);
            check("rd", bus.rd, q[0].rd);
            check("slt_sel", bus.slt_sel, q[0].slt);
            check("illegal", bus.illegal, q[0].ill);
        end
        acc = bus.instr_valid && q.size() < 2;
        con = q.size() > 0 && bus.ex_ready;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(bus.instr));
        end
        #1;
    endtask

    task automatic send(input logic [31:0] ins);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ex_valid"}, bus.ex_valid, 1'b0);
        check({tag, "_ready"}, bus.instr_ready, 1'b1);
        check({tag, "_A"}, bus.A, 32'd0);
        check({tag, "_B"}, bus.B, 32'd0);
        check({tag, "_alu"}, bus.ALUControl, 4'b0010);
        check({tag, "_rd"}, bus.rd, 5'd0);
        check({tag, "_slt"}, bus.slt_sel, 1'b0);
        check({tag, "_ill"}, bus.illegal, 1'b0);
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;   // add  x3,x1,x2
    localparam logic [31:0] I_SUB  = 32'h402081B3;   // sub  x3,x1,x2
    localparam logic [31:0] I_XOR  = 32'h0020C1B3;   // xor  x3,x1,x2
    localparam logic [31:0] I_SRAI = 32'h4040D213;   // srai x4,x1,4
    localparam logic [31:0] I_ADDI = 32'hFFF00093;   // addi x1,x0,-1
    localparam logic [31:0] I_SLTI = 32'h0030A293;   // slti x5,x1,3
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;   // sltu x3,x1,x2
    localparam logic [31:0] I_LW   = 32'h0000A183;   // lw   x3,0(x1)

    initial begin
        foreach (regs[i]) regs[i] = 32'd0;
        regs[1]         = 32'd5;
        regs[2]         = 32'd7;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.ex_ready    = 1'b1;

        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        send(I_ADD); cycle(); bus.instr_valid = 1'b0;
        check("add_A", bus.A, 32'd5);
        check("add_B", bus.B, 32'd7);
        check("add_alu", bus.ALUControl, 4'b0010);
        check("add_rd", bus.rd, 5'd3);
        cycle();

        regs[1] = 32'h80000000;
        send(I_SRAI); cycle(); bus.instr_valid = 1'b0;
        check("srai_B", bus.B, 32'd4);
        check("srai_alu", bus.ALUControl, 4'b0111);
        check("srai_ill", bus.illegal, 1'b0);
        send(I_ADDI); cycle();
        check("addi_B", bus.B, 32'hFFFFFFFF);
        send(I_SLTI); cycle();
        check("slti_alu", bus.ALUControl, 4'b0110);
        check("slti_slt", bus.slt_sel, 1'b1);
        send(I_SLTU); cycle();
        check("sltu_ill", bus.illegal, 1'b1);
        check("sltu_alu", bus.ALUControl, 4'b0010);
        check("sltu_rd", bus.rd, 5'd0);
        send(I_LW); cycle(); bus.instr_valid = 1'b0;
        check("lw_ill", bus.illegal, 1'b1);
        check("lw_valid", bus.ex_valid, 1'b1);
        cycle();

        // Back-pressure across ADD, SUB, XOR
        regs[1] = 32'd20;
        bus.ex_ready = 1'b0;
        send(I_ADD); cycle();
        send(I_SUB); cycle();
        check("bp_ready_low", bus.instr_ready, 1'b0);
        send(I_XOR); cycle();
        check("bp_hold_alu", bus.ALUControl, 4'b0010);
        bus.ex_ready = 1'b1;
        cycle();
        check("bp_sub_alu", bus.ALUControl, 4'b0110);
        cycle(); bus.instr_valid = 1'b0;
        check("bp_xor_alu", bus.ALUControl, 4'b0011);
        cycle();
        check("bp_drained", bus.ex_valid, 1'b0);

        // Flush with output and skid full, instr offered alongside
        bus.ex_ready = 1'b0;
        send(I_ADD); cycle();
        send(I_SUB); cycle();
        send(I_XOR); flush = 1'b1; bus.ex_ready = 1'b1; cycle(); flush = 1'b0;
        bus.instr_valid = 1'b0;
        check("flush_valid", bus.ex_valid, 1'b0);
        check("flush_ready", bus.instr_ready, 1'b1);
        // Flush with one entry and a real accept in the same cycle
        bus.ex_ready = 1'b0;
        send(I_ADD); cycle();
        send(I_SUB); flush = 1'b1; cycle(); flush = 1'b0;
        bus.instr_valid = 1'b0;
        check("flush_acc_valid", bus.ex_valid, 1'b0);
        cycle();

        // Asynchronous reset mid-stream
        send(I_ADD); cycle();
        send(I_SLTI); cycle();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        q.delete();
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.ex_ready = 1'b1;
        cycle();

        // Randomized traffic
        foreach (regs[i]) regs[i] = (i == 0) ? 32'd0 : $urandom;
        for (int n = 0; n < 3000; n++) begin
            bus.instr       = rand_instr();
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.ex_ready    = ($urandom_range(0, 2) != 0);
            flush           = ($urandom_range(0, 49) == 0);
            cycle();
        end
        flush           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.ex_ready    = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
